// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR stream checker:
//   - LFSR_W          : LFSR length / history window (polynomial x^6+x^5+1)
//   - TAP_HI, TAP_LO  : feedback taps of the forward recurrence
//   - state_t         : checker FSM states
//   - pred_up/down    : next-bit predictors for each stream direction
// ---------------------------------------------------------------------------
package lfsr_pkg;

    localparam int LFSR_W = 6;
    localparam int TAP_HI = 5;
    localparam int TAP_LO = 4;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // h[0] is the newest bit, so h[5] is b(t-6) and h[4] is b(t-5).
    // Forward: b(t) = b(t-6) ^ b(t-5)
    function automatic logic pred_up(input logic [LFSR_W-1:0] h);
        return h[TAP_HI] ^ h[TAP_LO];
    endfunction

    // Reverse: the time-reversed sequence obeys b(t) = b(t-6) ^ b(t-1)
    function automatic logic pred_down(input logic [LFSR_W-1:0] h);
        return h[TAP_HI] ^ h[0];
    endfunction

endpackage

// File: rtl/lfsr_stream_checker_if.sv
// ---------------------------------------------------------------------------
// lfsr_stream_checker_if
// Groups the serial stream input and the checker status outputs.
//   en       : stream bit valid this cycle
//   up_down  : stream direction, 1 = forward, 0 = reverse
//   bit_str  : serial stream bit
//   locked   : checker is locked to the stream
//   err      : one-cycle pulse per mismatched bit while locked
//   err_cnt  : saturating error count since reset
// Handshake: en is a valid-only qualifier; the checker has no ready and
// consumes every bit on the rising edge where en=1. Bits with en=0 are
// ignored and must not be retried.
// ---------------------------------------------------------------------------
interface lfsr_stream_checker_if #(
    parameter int ERR_W = 8
);
    logic             en;
    logic             up_down;
    logic             bit_str;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output en, up_down, bit_str,
        input  locked, err, err_cnt
    );

    modport slave (
        input  en, up_down, bit_str,
        output locked, err, err_cnt
    );
endinterface

// File: rtl/lfsr_hist_pred.sv
// ---------------------------------------------------------------------------
// lfsr_hist_pred
// History shift register of the last LFSR_W accepted bits plus the
// direction-selected prediction of the next bit.
//   clk, rst  : clock, asynchronous active-high reset
//   en        : accept bit_str this cycle
//   up_down   : selects the forward or reverse predictor
//   bit_str   : incoming bit
//   h         : history, h[0] newest
//   p         : predicted value of the bit being accepted (from h pre-shift)
// ---------------------------------------------------------------------------
module lfsr_hist_pred
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              up_down,
    input  logic              bit_str,
    output logic [LFSR_W-1:0] h,
    output logic              p
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h <= '0;
        end else if (en) begin
            h <= {h[LFSR_W-2:0], bit_str};
        end
    end

    assign p = up_down ? pred_up(h) : pred_down(h);

endmodule

// File: rtl/lfsr_stream_checker.sv
// ---------------------------------------------------------------------------
// lfsr_stream_checker
// PRBS checker for the 6-bit up/down LFSR serial output. Fills a history
// window, checks predictions until LOCK_CNT consecutive matches, then counts
// mismatches while locked and re-acquires after LOSS_CNT consecutive errors.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : stream in (en, up_down, bit_str), status out (locked, err,
//              err_cnt)
//   state    : FSM state, for debug/observation
//   hist     : history window, for debug/observation
// ---------------------------------------------------------------------------
module lfsr_stream_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    lfsr_stream_checker_if.slave  bus,
    output state_t                state,
    output logic [LFSR_W-1:0]     hist
);

    localparam logic [2:0]       FILL_LAST = 3'(LFSR_W - 1);
    localparam logic [7:0]       LOCK_V    = 8'(LOCK_CNT);
    localparam logic [7:0]       LOSS_V    = 8'(LOSS_CNT);
    localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

    logic [LFSR_W-1:0] h;
    logic              p;

    state_t            state_q, state_n;
    logic [2:0]        fill_q,  fill_n;
    logic [7:0]        good_q,  good_n;
    logic [7:0]        bad_q,   bad_n;
    logic              dir_q,   dir_n;
    logic              locked_q, locked_n;
    logic              err_q,   err_n;
    logic [ERR_W-1:0]  cnt_q,   cnt_n;

    logic              match;
    logic              zero_next;
    logic [7:0]        good_inc;
    logic [7:0]        bad_inc;

    lfsr_hist_pred u_hist_pred (
        .clk     (clk),
        .rst     (rst),
        .en      (bus.en),
        .up_down (bus.up_down),
        .bit_str (bus.bit_str),
        .h       (h),
        .p       (p)
    );

    assign match     = (bus.bit_str == p);
    // The history after this bit is shifted in; all-zero is the LFSR lock-up
    // pattern and can never be a valid window.
    assign zero_next = ({h[LFSR_W-2:0], bus.bit_str} == '0);
    assign good_inc  = good_q + 8'd1;
    assign bad_inc   = bad_q + 8'd1;

    always_comb begin
        state_n  = state_q;
        fill_n   = fill_q;
        good_n   = good_q;
        bad_n    = bad_q;
        dir_n    = dir_q;
        locked_n = locked_q;
        err_n    = 1'b0;
        cnt_n    = cnt_q;

        if (bus.en) begin
            if (bus.up_down != dir_q) begin
                // The current bit becomes fill bit 1 of the new direction.
                dir_n    = bus.up_down;
                state_n  = FILL;
                locked_n = 1'b0;
                fill_n   = 3'd1;
                good_n   = '0;
                bad_n    = '0;
            end else begin
                case (state_q)
                    FILL: begin
                        if (fill_q == FILL_LAST) begin
                            fill_n = '0;
                            if (!zero_next) begin
                                state_n = CHECK;
                            end
                        end else begin
                            fill_n = fill_q + 3'd1;
                        end
                    end
                    CHECK: begin
                        if (match) begin
                            if (good_inc == LOCK_V) begin
                                state_n  = LOCKED;
                                locked_n = 1'b1;
                                good_n   = '0;
                            end else begin
                                good_n = good_inc;
                            end
                        end else begin
                            good_n = '0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            bad_n = '0;
                        end else begin
                            // The deciding error is still reported when it
                            // also drops lock.
                            err_n = 1'b1;
                            if (cnt_q != '1) begin
                                cnt_n = cnt_q + ERR_ONE;
                            end
                            if (bad_inc == LOSS_V) begin
                                state_n  = FILL;
                                locked_n = 1'b0;
                                fill_n   = '0;
                                good_n   = '0;
                                bad_n    = '0;
                            end else begin
                                bad_n = bad_inc;
                            end
                        end
                    end
                    default: begin
                        state_n = FILL;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FILL;
            fill_q   <= '0;
            good_q   <= '0;
            bad_q    <= '0;
            dir_q    <= 1'b1;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_n;
            fill_q   <= fill_n;
            good_q   <= good_n;
            bad_q    <= bad_n;
            dir_q    <= dir_n;
            locked_q <= locked_n;
            err_q    <= err_n;
            cnt_q    <= cnt_n;
        end
    end

    assign bus.locked  = locked_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = cnt_q;
    assign state       = state_q;
    assign hist        = h;

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_stream_checker
// Directed bench for lfsr_stream_checker. Instance a uses the default
// parameters; instance b uses LOSS_CNT=255 for the saturation scenario.
// The bench's bit generator only produces stimulus; every expected value is
// a hand-derived constant.
// ---------------------------------------------------------------------------
module tb_lfsr_stream_checker;
    import lfsr_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lfsr_stream_checker_if #(.ERR_W(8)) bus_a ();
    lfsr_stream_checker_if #(.ERR_W(8)) bus_b ();

    state_t     state_a, state_b;
    logic [5:0] hist_a, hist_b;

    lfsr_stream_checker #(.LOCK_CNT(8), .LOSS_CNT(4), .ERR_W(8)) dut_a (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_a),
        .state (state_a),
        .hist  (hist_a)
    );

    lfsr_stream_checker #(.LOCK_CNT(8), .LOSS_CNT(255), .ERR_W(8)) dut_b (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus_b),
        .state (state_b),
        .hist  (hist_b)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [5:0] g;         // generator history, g[0] newest true bit
    logic       use_b = 1'b0;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // at the same point, after the edge that consumed the bit.
    task automatic step(input logic e, input logic ud, input logic b);
        if (use_b) begin
            bus_b.en = e; bus_b.up_down = ud; bus_b.bit_str = b;
            bus_a.en = 1'b0;
        end else begin
            bus_a.en = e; bus_a.up_down = ud; bus_a.bit_str = b;
            bus_b.en = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input logic ud, input logic b);
        g = {g[4:0], b};
        step(1'b1, ud, b);
    endtask

    // Next true stream bit in direction ud, optionally sent inverted.
    task automatic send_gen(input logic ud, input logic inv);
        logic nb;
        nb = ud ? (g[5] ^ g[4]) : (g[5] ^ g[0]);
        g  = {g[4:0], nb};
        step(1'b1, ud, nb ^ inv);
    endtask

    task automatic seed(input logic ud);
        g = '0;
        send_raw(ud, 1'b1);
        for (int i = 0; i < 5; i++) send_raw(ud, 1'b0);
    endtask

    task automatic do_reset();
        bus_a.en = 1'b0; bus_b.en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        bus_a.en = 1'b0; bus_a.up_down = 1'b1; bus_a.bit_str = 1'b0;
        bus_b.en = 1'b0; bus_b.up_down = 1'b1; bus_b.bit_str = 1'b0;
        g = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked",  32'(bus_a.locked),  32'd0);
        check("rst_err",     32'(bus_a.err),     32'd0);
        check("rst_err_cnt", 32'(bus_a.err_cnt), 32'd0);
        check("rst_state",   32'(state_a),       32'(FILL));
        check("rst_hist",    32'(hist_a),        32'd0);
        rst = 1'b0;

        // Forward acquire: 6 fill bits + 8 good bits.
        g = '0;
        send_raw(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send_raw(1'b1, 1'b0);
            if (i == 3) check("fwd_fill5_state", 32'(state_a), 32'(FILL));
        end
        check("fwd_fill6_state", 32'(state_a), 32'(CHECK));
        check("fwd_hist",        32'(hist_a),  32'h20);
        for (int i = 0; i < 7; i++) send_gen(1'b1, 1'b0);
        check("fwd_bit13_unlocked", 32'(bus_a.locked), 32'd0);
        send_gen(1'b1, 1'b0);
        check("fwd_bit14_locked", 32'(bus_a.locked),  32'd1);
        check("fwd_lock_state",   32'(state_a),       32'(LOCKED));
        check("fwd_err",          32'(bus_a.err),     32'd0);
        check("fwd_err_cnt",      32'(bus_a.err_cnt), 32'd0);

        // Gating: en 1,0,0,1 with garbage (and a flipped direction) while idle.
        send_gen(1'b1, 1'b0);
        check("gate_en1_err", 32'(bus_a.err), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check("gate_idle_err",    32'(bus_a.err),    32'd0);
            check("gate_idle_locked", 32'(bus_a.locked), 32'd1);
        end
        send_gen(1'b1, 1'b0);
        check("gate_resume_err",    32'(bus_a.err),     32'd0);
        check("gate_resume_locked", 32'(bus_a.locked),  32'd1);
        check("gate_err_cnt",       32'(bus_a.err_cnt), 32'd0);

        // Single inverted bit: one pulse, count 1, still locked.
        send_gen(1'b1, 1'b1);
        check("single_err_pulse",  32'(bus_a.err),     32'd1);
        check("single_err_cnt",    32'(bus_a.err_cnt), 32'd1);
        check("single_err_locked", 32'(bus_a.locked),  32'd1);
        send_gen(1'b1, 1'b0);
        check("single_err_end", 32'(bus_a.err), 32'd0);
        // The corrupted bit sits in the checker's window and spoils the
        // predictions 5 and 6 bits later (taps b(t-5), b(t-6)): two more
        // errors, never consecutive beyond 2, so lock holds.
        for (int i = 2; i <= 10; i++) begin
            send_gen(1'b1, 1'b0);
            if (i == 5) check("echo_err_t5", 32'(bus_a.err), 32'd1);
            if (i == 7) check("echo_err_t7", 32'(bus_a.err), 32'd0);
        end
        check("echo_err_cnt", 32'(bus_a.err_cnt), 32'd3);
        check("echo_locked",  32'(bus_a.locked),  32'd1);

        // Burst of 4 inverted bits: all mismatch, lock drops on the 4th.
        for (int k = 1; k <= 4; k++) begin
            send_gen(1'b1, 1'b1);
            if (k == 3) check("burst3_locked", 32'(bus_a.locked), 32'd1);
        end
        check("burst4_locked",  32'(bus_a.locked),  32'd0);
        check("burst4_err",     32'(bus_a.err),     32'd1);
        check("burst4_err_cnt", 32'(bus_a.err_cnt), 32'd7);
        check("burst4_state",   32'(state_a),       32'(FILL));

        // Re-acquire keeps the error count.
        for (int i = 0; i < 13; i++) send_gen(1'b1, 1'b0);
        check("reacq_bit13_unlocked", 32'(bus_a.locked), 32'd0);
        send_gen(1'b1, 1'b0);
        check("reacq_locked",  32'(bus_a.locked),  32'd1);
        check("reacq_err_cnt", 32'(bus_a.err_cnt), 32'd7);

        // Async reset mid-cycle while locked and err is pulsing.
        send_gen(1'b1, 1'b1);
        check("pre_rst_err",     32'(bus_a.err),     32'd1);
        check("pre_rst_err_cnt", 32'(bus_a.err_cnt), 32'd8);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_locked",  32'(bus_a.locked),  32'd0);
        check("async_rst_err",     32'(bus_a.err),     32'd0);
        check("async_rst_err_cnt", 32'(bus_a.err_cnt), 32'd0);
        check("async_rst_state",   32'(state_a),       32'(FILL));
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) send_gen(1'b1, 1'b0);
        check("post_rst_fill5", 32'(state_a), 32'(FILL));
        send_gen(1'b1, 1'b0);
        check("post_rst_fill6", 32'(state_a), 32'(CHECK));

        // Reverse stream. The first bit differs from the reset direction,
        // so it counts as fill bit 1; lock timing is unchanged.
        do_reset();
        seed(1'b0);
        check("rev_fill6_state", 32'(state_a), 32'(CHECK));
        check("rev_fill_err",    32'(bus_a.err), 32'd0);
        for (int i = 0; i < 7; i++) send_gen(1'b0, 1'b0);
        check("rev_bit13_unlocked", 32'(bus_a.locked), 32'd0);
        send_gen(1'b0, 1'b0);
        check("rev_bit14_locked", 32'(bus_a.locked),  32'd1);
        check("rev_err_cnt",      32'(bus_a.err_cnt), 32'd0);
        send_gen(1'b0, 1'b0);
        send_gen(1'b0, 1'b0);
        check("rev_still_locked", 32'(bus_a.locked), 32'd1);

        // Direction flip: lock drops, no error, 5 more fill + 8 good.
        send_gen(1'b1, 1'b0);
        check("flip_locked",  32'(bus_a.locked),  32'd0);
        check("flip_err",     32'(bus_a.err),     32'd0);
        check("flip_state",   32'(state_a),       32'(FILL));
        check("flip_err_cnt", 32'(bus_a.err_cnt), 32'd0);
        for (int i = 0; i < 5; i++) send_gen(1'b1, 1'b0);
        check("flip_refill_state", 32'(state_a), 32'(CHECK));
        for (int i = 0; i < 7; i++) send_gen(1'b1, 1'b0);
        check("flip_pre_relock", 32'(bus_a.locked), 32'd0);
        send_gen(1'b1, 1'b0);
        check("flip_relocked", 32'(bus_a.locked),  32'd1);
        check("flip_relock_cnt", 32'(bus_a.err_cnt), 32'd0);

        // Lock-up: an all-zero stream never leaves FILL.
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0);
        check("lockup6_state", 32'(state_a), 32'(FILL));
        for (int i = 0; i < 24; i++) step(1'b1, 1'b1, 1'b0);
        check("lockup30_state",  32'(state_a),       32'(FILL));
        check("lockup30_locked", 32'(bus_a.locked),  32'd0);
        check("lockup30_cnt",    32'(bus_a.err_cnt), 32'd0);
        seed(1'b1);
        check("lockup_exit", 32'(state_a), 32'(CHECK));

        // Saturation on instance b (LOSS_CNT=255).
        use_b = 1'b1;
        do_reset();
        seed(1'b1);
        for (int i = 0; i < 8; i++) send_gen(1'b1, 1'b0);
        check("sat_locked", 32'(bus_b.locked), 32'd1);
        // A fully inverted run mismatches on every bit except the 6th, where
        // one inverted and one true tap cancel the inversion: 199 errors.
        for (int i = 0; i < 200; i++) send_gen(1'b1, 1'b1);
        check("sat_block1_cnt",    32'(bus_b.err_cnt), 32'd199);
        check("sat_block1_locked", 32'(bus_b.locked),  32'd1);
        send_gen(1'b1, 1'b0);
        check("sat_true_bit_err", 32'(bus_b.err), 32'd0);
        // 100 more inverted bits give 98 errors: 297 total, clamped.
        for (int i = 0; i < 100; i++) send_gen(1'b1, 1'b1);
        check("sat_cnt_ff",     32'(bus_b.err_cnt), 32'hFF);
        check("sat_err_pulse",  32'(bus_b.err),     32'd1);
        check("sat_locked_end", 32'(bus_b.locked),  32'd1);
        check("sat_a_idle_cnt", 32'(bus_a.err_cnt), 32'd0);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
